// File: rtl/iobus_hub.sv
// Memory-mapped IO hub: registered output ports, synchronized input ports,
// MCU clock-enable divider and a sticky flag for writes to unmapped addresses.
module iobus_hub #(
    parameter int unsigned N_OUT     = 2,
    parameter int unsigned N_IN      = 2,
    parameter logic [31:0] ADDR_BASE = 32'h1100_0000,
    parameter int unsigned DIV       = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           IOBUS_ADDR,
    input  logic [31:0]           IOBUS_OUT,
    input  logic                  IOBUS_WR,
    output logic [31:0]           IOBUS_IN,
    input  logic [32*N_IN-1:0]    IN_PORTS,
    output logic [32*N_OUT-1:0]   OUT_PORTS,
    output logic                  CLK_EN,
    output logic                  BAD_ADDR
);

    localparam logic [7:0]  CNT_MAX   = 8'(DIV - 1);
    localparam logic [29:0] OUT_WORDS = 30'(N_OUT);
    localparam logic [29:0] CLR_WORD  = 30'(N_IN);

    logic [7:0]              div_cnt;
    logic [31:0]             offset;
    logic [29:0]             word;
    logic                    aligned;
    logic                    out_hit;
    logic                    clr_hit;
    logic                    wr_acc;
    logic [N_OUT-1:0][31:0]  out_q;
    logic [N_IN-1:0][31:0]   sync_a;
    logic [N_IN-1:0][31:0]   sync_b;
    logic                    bad_q;
    logic [31:0]             rd_data;

    // Divider: CLK_EN is the terminal count, so DIV=1 keeps it high permanently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt <= '0;
        end else if (div_cnt == CNT_MAX) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign CLK_EN = (div_cnt == CNT_MAX);

    // Decode relative to the base; addresses below the base wrap to huge offsets.
    assign offset  = IOBUS_ADDR - ADDR_BASE;
    assign word    = offset[31:2];
    assign aligned = (offset[1:0] == 2'b00);
    assign out_hit = aligned && (word < OUT_WORDS);
    assign clr_hit = aligned && (word == CLR_WORD);
    assign wr_acc  = IOBUS_WR && CLK_EN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q <= '0;
        end else if (wr_acc && out_hit) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (word == 30'(k)) begin
                    out_q[k] <= IOBUS_OUT;
                end
            end
        end
    end

    assign OUT_PORTS = out_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            bad_q <= 1'b0;
        end else if (wr_acc) begin
            if (clr_hit && IOBUS_OUT[0]) begin
                bad_q <= 1'b0;
            end else if (!out_hit && !clr_hit) begin
                bad_q <= 1'b1;
            end
        end
    end

    assign BAD_ADDR = bad_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= IN_PORTS;
            sync_b <= sync_a;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (aligned && (word == 30'(k))) begin
                rd_data = sync_b[k];
            end
        end
        if (clr_hit) begin
            rd_data = {31'b0, bad_q};
        end
    end

    assign IOBUS_IN = rd_data;

endmodule

// File: tb/tb_iobus_hub.sv
// Bench for iobus_hub: address-level behavioural model checked every cycle,
// plus directed writes/reads with literal expectations.
module tb_iobus_hub;

    localparam logic [31:0] BASE = 32'h1100_0000;
    localparam int unsigned DIVM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr = 1'b0;
    logic [63:0] in_ports = '0;
    logic [31:0] rd;
    logic [63:0] outp;
    logic        en;
    logic        bad;

    logic [31:0] rd1;
    logic [63:0] outp1;
    logic        en1;
    logic        bad1;

    int total = 0;
    int bad_cnt = 0;

    always #5 clk = ~clk;

    iobus_hub #(.N_OUT(2), .N_IN(2), .ADDR_BASE(BASE), .DIV(DIVM)) dut (
        .CLK(clk), .RST(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata), .IOBUS_WR(wr),
        .IOBUS_IN(rd), .IN_PORTS(in_ports), .OUT_PORTS(outp), .CLK_EN(en), .BAD_ADDR(bad)
    );

    iobus_hub #(.N_OUT(2), .N_IN(2), .ADDR_BASE(BASE), .DIV(1)) dut1 (
        .CLK(clk), .RST(rst), .IOBUS_ADDR(32'h0), .IOBUS_OUT(32'h0), .IOBUS_WR(1'b0),
        .IOBUS_IN(rd1), .IN_PORTS(64'h0), .OUT_PORTS(outp1), .CLK_EN(en1), .BAD_ADDR(bad1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: cycles since reset, output words, flag, per-edge input samples.
    typedef struct { bit r; logic [63:0] v; } samp_t;
    int unsigned m_cyc = 0;
    bit          started = 0;
    logic [31:0] m_out [2];
    logic        m_bad;
    samp_t       hist[$];

    function automatic bit m_en();
        return started && ((m_cyc % DIVM) == DIVM - 1);
    endfunction

    // Value seen two edges ago, or zero if either of the last two edges was a reset.
    function automatic logic [63:0] m_synced();
        if (hist.size() < 2) return '0;
        if (hist[0].r || hist[1].r) return '0;
        return hist[0].v;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        logic [63:0] s;
        off = a - BASE;
        s = m_synced();
        if (off == 32'd0) return s[31:0];
        if (off == 32'd4) return s[63:32];
        if (off == 32'd8) return {31'b0, m_bad};
        return '0;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] off;
        samp_t s;
        if (rst) begin
            m_cyc = 0;
            m_out[0] = '0;
            m_out[1] = '0;
            m_bad = 1'b0;
            started = 1;
        end else if (started) begin
            if (wr && m_en()) begin
                off = addr - BASE;
                if (off == 32'd0) m_out[0] = wdata;
                else if (off == 32'd4) m_out[1] = wdata;
                else if (off == 32'd8) begin
                    if (wdata[0]) m_bad = 1'b0;
                end else m_bad = 1'b1;
            end
            m_cyc++;
        end
        s.r = rst;
        s.v = in_ports;
        hist.push_back(s);
        if (hist.size() > 2) void'(hist.pop_front());
    end

    always @(negedge clk) begin
        if (started) begin
            check("clk_en", {63'b0, en}, {63'b0, m_en()});
            check("clk_en_div1", {63'b0, en1}, 64'd1);
            check("out_ports", outp, {m_out[1], m_out[0]});
            check("bad_addr", {63'b0, bad}, {63'b0, m_bad});
            check("iobus_in", {32'b0, rd}, {32'b0, m_read(addr)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!m_en() && n < 2 * DIVM) begin
            tick();
            n++;
        end
        if (!m_en()) begin
            total++;
            bad_cnt++;
            $display("FAIL wait_en: got timeout expected clk_en within %0d cycles", 2 * DIVM);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        wait_en();
        addr = a;
        wdata = d;
        wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic write_gated(input logic [31:0] a, input logic [31:0] d);
        if (m_en()) tick();
        addr = a;
        wdata = d;
        wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_out", outp, 64'h0);
        check("rst_bad", {63'b0, bad}, 64'h0);
        check("rst_en", {63'b0, en}, 64'h0);

        for (int i = 0; i < 12; i++) begin
            check("div_phase", {63'b0, en}, {63'b0, (i == 3 || i == 7 || i == 11)});
            tick();
        end

        do_write(BASE + 32'd4, 32'hDEAD_BEEF);
        check("wr_port1", {32'b0, outp[63:32]}, 64'hDEAD_BEEF);
        check("wr_port0_hold", {32'b0, outp[31:0]}, 64'h0);
        write_gated(BASE + 32'd4, 32'h1234_5678);
        check("wr_gated", {32'b0, outp[63:32]}, 64'hDEAD_BEEF);
        do_write(BASE, 32'h0000_1111);
        check("wr_port0", {32'b0, outp[31:0]}, 64'h1111);

        in_ports[31:0] = 32'h0000_00A5;
        addr = BASE;
        #1;
        check("sync_e0", {32'b0, rd}, 64'h0);
        tick();
        check("sync_e1", {32'b0, rd}, 64'h0);
        tick();
        check("sync_e2", {32'b0, rd}, 64'hA5);
        in_ports[63:32] = 32'h55AA_0001;
        addr = BASE + 32'd4;
        tick();
        tick();
        check("sync_port1", {32'b0, rd}, 64'h55AA_0001);
        addr = BASE + 32'd12;
        #1;
        check("rd_unmapped", {32'b0, rd}, 64'h0);
        addr = BASE + 32'd1;
        #1;
        check("rd_misaligned", {32'b0, rd}, 64'h0);
        addr = BASE + 32'd8;
        #1;
        check("rd_flag_clear", {32'b0, rd}, 64'h0);

        do_write(BASE + 32'h40, 32'hCAFE_F00D);
        check("bad_set", {63'b0, bad}, 64'h1);
        check("bad_out_hold", outp, 64'hDEAD_BEEF_0000_1111);
        addr = BASE + 32'd8;
        #1;
        check("rd_flag_set", {32'b0, rd}, 64'h1);
        do_write(BASE + 32'd8, 32'h2);
        check("bad_keep_bit0_0", {63'b0, bad}, 64'h1);
        do_write(BASE + 32'd8, 32'h1);
        check("bad_clear", {63'b0, bad}, 64'h0);
        check("clear_out_hold", outp, 64'hDEAD_BEEF_0000_1111);

        write_gated(BASE + 32'h40, 32'h0);
        check("gated_no_bad", {63'b0, bad}, 64'h0);

        do_write(BASE + 32'd2, 32'h0000_AAAA);
        check("misalign_bad", {63'b0, bad}, 64'h1);
        check("misalign_hold", {32'b0, outp[31:0]}, 64'h1111);
        do_write(BASE + 32'd8, 32'h1);
        do_write(BASE - 32'd4, 32'h7);
        check("below_base_bad", {63'b0, bad}, 64'h1);

        wait_en();
        addr = BASE;
        wdata = 32'hFFFF_FFFF;
        wr = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr = 1'b0;
        check("coll_out", outp, 64'h0);
        check("coll_bad", {63'b0, bad}, 64'h0);
        check("coll_sync", {32'b0, rd}, 64'h0);
        for (int i = 0; i < 8; i++) begin
            check("coll_phase", {63'b0, en}, {63'b0, (i == 3 || i == 7)});
            tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule
